latch_exerciser: RTL
====================

Name: latch_exerciser

Overview:
- Synthesizable stimulus generator and checker that sits directly upstream and downstream of the latches block.
- Drives the latch inputs a, b, preset and clr through a fixed reset-then-vector sequence.
- Samples the selected latch's Q/Qn, compares them against an internal reference model, and reports an error count and a pass flag.
- Replaces hand-timed bench stimulus, so latch checks run identically in simulation and on FPGA.

Parameters:
CLR_CYCLES, 8, cycles clr is held high before vectors are applied (min 1)
HOLD_CYCLES, 4, cycles each (a,b) vector is held (min 2)
ERR_W, 8, width of err_count

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a run; sampled only in IDLE or DONE
mode  input  2  latch under test: 00 SR, 01 JK, 10 D, 11 invalid; captured at start
q  input  1  Q from the selected latch output
qn  input  1  Qn from the selected latch output
a  output  1  latch input a (S / J / D)
b  output  1  latch input b (R / K / enable)
preset  output  1  latch preset; always 0 in this block
clr  output  1  latch clear
busy  output  1  high from CLEAR through the last APPLY cycle
done  output  1  high in DONE; holds until the next accepted start
pass  output  1  done and err_count==0
err_count  output  ERR_W  number of mismatching steps, saturating
step_idx  output  2  index of the vector being applied

Behaviour:
- Reset (async, rst_n=0): state=IDLE; a, b, preset, clr, busy, done, pass = 0; err_count=0; step_idx=0; model state=0.
- All outputs are registered.
- States: IDLE, CLEAR, RELEASE, APPLY, DONE.
- IDLE or DONE with start=1:
  - Capture mode, clear err_count, done and pass.
  - Go to CLEAR, or go to DONE if mode=11.
- mode=11: DONE is reached one cycle after start, with err_count=1 and pass=0. No stimulus is driven.
- CLEAR: clr=1, a=b=0 for exactly CLR_CYCLES cycles. The model state is set to 0.
- RELEASE: one cycle with clr=0, a=b=0.
- APPLY: for step k=0..3, drive {a,b} = 00, 01, 10, 11 in that order, each for HOLD_CYCLES cycles. step_idx=k.
- Sampling: q and qn are sampled on the last cycle of each hold.
  - A step fails if q != expected or qn != ~expected.
  - Each failing step adds 1 to err_count. err_count saturates at all-ones.
- Reference model (expected value after applying the vector; model state carries between steps):
  - SR (a=S, b=R): 00 hold, 01 → 0, 10 → 1, 11 not compared.
  - JK (a=J, b=K): 00 hold, 01 → 0, 10 → 1, 11 not compared (a level-sensitive latch races).
  - D (a=D, b=EN): 00 hold, 01 → 0, 10 hold, 11 → 1. All four steps are compared.
- After step 3: enter DONE. busy=0, done=1, pass=(err_count==0), and a=b=clr=0.
- Timing with defaults: start sampled at edge 0 → CLEAR on cycles 1–8, RELEASE on cycle 9, APPLY on cycles 10–25, done=1 from cycle 26.
- General form: done asserts CLR_CYCLES + 4*HOLD_CYCLES + 2 cycles after start.
- start while busy is ignored, and mode changes mid-run are ignored.
- start in DONE restarts the run (done drops on the next cycle).
- rst_n low at any point, including mid-APPLY, returns all outputs to reset values immediately (asynchronously).
- preset is tied low in every state; it is reserved for a later preset-sequence extension.

Test Plan:
- Ideal SR latch model, mode=00, defaults, start pulse at cycle 0 → clr high for cycles 1–8, vectors 00/01/10/11 on cycles 10–25, done=1 at cycle 26, err_count=0, pass=1.
- SR mode with q stuck at 0 and qn stuck at 1 → step 2 (10) fails, step 3 is skipped; err_count=1, pass=0.
- Ideal D latch model, mode=10 → all 4 steps are compared with expected values 0, 0, 0, 1; err_count=0, pass=1. Repeating the run with q/qn swapped → err_count=4.
- ERR_W=1, D mode with inverted outputs → err_count saturates at 1 and does not wrap; pass=0.
- start re-pulsed during APPLY step 1 with mode changed to 01 → no restart, and the run finishes with done at cycle 26.
- rst_n pulled low during APPLY step 2 → a=b=clr=busy=done=0 and err_count=0 immediately. After release, the block sits in IDLE until start. mode=11 → done on the next cycle with err_count=1.

Source files
------------

// File: rtl/latch_exerciser.sv
// Self-contained stimulus generator and checker for the SR/JK/D latch block:
// clears the latch, walks four (a,b) vectors, and scores Q/Qn against a reference model.
module latch_exerciser #(
    parameter int CLR_CYCLES  = 8,
    parameter int HOLD_CYCLES = 4,
    parameter int ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic             q,
    input  logic             qn,
    output logic             a,
    output logic             b,
    output logic             preset,
    output logic             clr,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       step_idx
);

    localparam int CNT_MAX = (CLR_CYCLES > HOLD_CYCLES) ? CLR_CYCLES : HOLD_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] CLR_LOAD  = CNT_W'(CLR_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

    localparam logic [1:0] MODE_SR  = 2'b00;
    localparam logic [1:0] MODE_JK  = 2'b01;
    localparam logic [1:0] MODE_D   = 2'b10;
    localparam logic [1:0] MODE_BAD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RELEASE,
        ST_APPLY,
        ST_DONE
    } state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [1:0]         mode_q, mode_d;
    logic               model, model_d;
    logic               a_d, b_d, clr_d, busy_d, done_d, pass_d;
    logic [ERR_W-1:0]   err_d, err_bump;
    logic [1:0]         step_d;
    logic               expected, compare, step_fail;

    // Reserved for a future preset sequence; the latch preset is never exercised here.
    assign preset = 1'b0;

    // Expected latch value after the current vector, given the carried model state.
    always_comb begin
        expected = model;
        compare  = 1'b1;
        case (mode_q)
            MODE_SR, MODE_JK: begin
                case (step_idx)
                    2'd1:    expected = 1'b0;
                    2'd2:    expected = 1'b1;
                    2'd3:    compare  = 1'b0;
                    default: expected = model;
                endcase
            end
            MODE_D: begin
                case (step_idx)
                    2'd1:    expected = 1'b0;
                    2'd3:    expected = 1'b1;
                    default: expected = model;
                endcase
            end
            default: compare = 1'b0;
        endcase
    end

    assign step_fail = compare && ((q != expected) || (qn != ~expected));
    assign err_bump  = (&err_count) ? err_count : err_count + ERR_W'(1);

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        mode_d  = mode_q;
        model_d = model;
        a_d     = a;
        b_d     = b;
        clr_d   = clr;
        busy_d  = busy;
        done_d  = done;
        pass_d  = pass;
        err_d   = err_count;
        step_d  = step_idx;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    mode_d = mode;
                    done_d = 1'b0;
                    pass_d = 1'b0;
                    err_d  = '0;
                    a_d    = 1'b0;
                    b_d    = 1'b0;
                    if (mode == MODE_BAD) begin
                        // Invalid selection is reported as a single error with no stimulus.
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        err_d   = ERR_W'(1);
                        busy_d  = 1'b0;
                        clr_d   = 1'b0;
                    end else begin
                        state_d = ST_CLEAR;
                        clr_d   = 1'b1;
                        busy_d  = 1'b1;
                        cnt_d   = CLR_LOAD;
                        step_d  = 2'd0;
                        model_d = 1'b0;
                    end
                end
            end
            ST_CLEAR: begin
                model_d = 1'b0;
                if (cnt == '0) begin
                    state_d = ST_RELEASE;
                    clr_d   = 1'b0;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                state_d = ST_APPLY;
                cnt_d   = HOLD_LOAD;
                a_d     = 1'b0;
                b_d     = 1'b0;
                step_d  = 2'd0;
            end
            ST_APPLY: begin
                if (cnt == '0) begin
                    // Last cycle of the hold: score the latch and advance.
                    model_d = expected;
                    err_d   = step_fail ? err_bump : err_count;
                    if (step_idx == 2'd3) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                        a_d     = 1'b0;
                        b_d     = 1'b0;
                    end else begin
                        step_d     = step_idx + 2'd1;
                        {a_d, b_d} = step_d;
                        cnt_d      = HOLD_LOAD;
                    end
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            mode_q    <= MODE_SR;
            model     <= 1'b0;
            a         <= 1'b0;
            b         <= 1'b0;
            clr       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            step_idx  <= 2'd0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            mode_q    <= mode_d;
            model     <= model_d;
            a         <= a_d;
            b         <= b_d;
            clr       <= clr_d;
            busy      <= busy_d;
            done      <= done_d;
            pass      <= pass_d;
            err_count <= err_d;
            step_idx  <= step_d;
        end
    end

endmodule
